// File: rtl/counter_bank_par.sv
// Bank of independent up-counters with synchronised enables, registered terminal-count
// status, sticky hit flags and a masked OR-reduced terminal-count flag.
module counter_bank_par #(
    parameter int NUM_CH      = 32,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] cen,
    input  logic [NUM_CH-1:0] mask,
    input  logic              sticky_clr,
    output logic [NUM_CH-1:0] term_vec,
    output logic [NUM_CH-1:0] sticky,
    output logic              cout
);

    logic [NUM_CH-1:0] tc;
    logic [NUM_CH-1:0] term_q;
    logic [NUM_CH-1:0] sticky_q;
    logic [NUM_CH-1:0] sticky_d;
    logic              cout_q;
    logic              cout_d;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   en;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;

        // cen is asynchronous; only the first synchroniser stage samples it.
        if (SYNC_STAGES == 1) begin : g_sync1
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= cen[gi];
                end
            end
        end else begin : g_syncn
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], cen[gi]};
                end
            end
        end

        assign en     = sync_q[SYNC_STAGES-1];
        assign tc[gi] = &cnt_q;

        always_comb begin
            cnt_d = cnt_q;
            if (!en) begin
                cnt_d = '0;
            end else if (!tc[gi]) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (SATURATE == 0) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // A terminal-count hit sets the sticky flag even when a clear arrives in the same cycle.
    assign sticky_d = term_q | (sticky_q & ~{NUM_CH{sticky_clr}});
    assign cout_d   = |(term_q & ~mask);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            term_q   <= '0;
            sticky_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            term_q   <= tc;
            sticky_q <= sticky_d;
            cout_q   <= cout_d;
        end
    end

    assign term_vec = term_q;
    assign sticky   = sticky_q;
    assign cout     = cout_q;

endmodule

// File: tb/tb_counter_bank_par.sv
// Self-checking bench: three configurations (wrap, saturate, 64-channel scale) checked
// against fixed timing tables, hand sequences and a cycle-level behavioural model.
module tb_counter_bank_par;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] cen_a [3];
    logic [63:0] mask_a [3];
    logic        clr_a [3];

    logic [7:0]  tv_w, st_w, tv_s, st_s;
    logic [63:0] tv_x, st_x;
    logic        co_w, co_s, co_x;

    int checks = 0;
    int errors = 0;

    // Behavioural model state, per instance k: 0 = wrap, 1 = saturate, 2 = scale.
    int          cnt_m  [3][64];
    logic [3:0]  hist_m [3][64];
    logic [63:0] tv_m   [3];
    logic [63:0] st_m   [3];
    logic        co_m   [3];

    always #5 clock = ~clock;

    counter_bank_par #(.NUM_CH(8), .CNT_W(4), .SYNC_STAGES(2), .SATURATE(0)) u_wrap (
        .clock(clock), .reset_n(reset_n), .cen(cen_a[0][7:0]), .mask(mask_a[0][7:0]),
        .sticky_clr(clr_a[0]), .term_vec(tv_w), .sticky(st_w), .cout(co_w));

    counter_bank_par #(.NUM_CH(8), .CNT_W(4), .SYNC_STAGES(2), .SATURATE(1)) u_sat (
        .clock(clock), .reset_n(reset_n), .cen(cen_a[1][7:0]), .mask(mask_a[1][7:0]),
        .sticky_clr(clr_a[1]), .term_vec(tv_s), .sticky(st_s), .cout(co_s));

    counter_bank_par #(.NUM_CH(64), .CNT_W(2), .SYNC_STAGES(1), .SATURATE(0)) u_scale (
        .clock(clock), .reset_n(reset_n), .cen(cen_a[2]), .mask(mask_a[2]),
        .sticky_clr(clr_a[2]), .term_vec(tv_x), .sticky(st_x), .cout(co_x));

    function automatic int p_n(int k);   return (k == 2) ? 64 : 8; endfunction
    function automatic int p_w(int k);   return (k == 2) ? 2 : 4;  endfunction
    function automatic int p_s(int k);   return (k == 2) ? 1 : 2;  endfunction
    function automatic bit p_sat(int k); return (k == 1);          endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            tv_m[k] = '0;
            st_m[k] = '0;
            co_m[k] = 1'b0;
            for (int i = 0; i < 64; i++) begin
                cnt_m[k][i]  = 0;
                hist_m[k][i] = '0;
            end
        end
    endtask

    // One clock edge of the specified rules, using the inputs present at that edge.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [63:0] ntv;
            logic [63:0] nst;
            int          maxv;
            ntv  = '0;
            nst  = '0;
            maxv = (1 << p_w(k)) - 1;
            co_m[k] = |(tv_m[k] & ~mask_a[k]);
            for (int i = 0; i < p_n(k); i++) begin
                logic en;
                en     = hist_m[k][i][p_s(k)-1];
                ntv[i] = (cnt_m[k][i] == maxv);
                nst[i] = tv_m[k][i] | (st_m[k][i] & ~clr_a[k]);
                if (!en)                     cnt_m[k][i] = 0;
                else if (cnt_m[k][i] < maxv) cnt_m[k][i] = cnt_m[k][i] + 1;
                else                         cnt_m[k][i] = p_sat(k) ? maxv : 0;
                hist_m[k][i] = {hist_m[k][i][2:0], cen_a[k][i]};
            end
            tv_m[k] = ntv;
            st_m[k] = nst;
        end
    endtask

    task automatic compare_all();
        chk("wrap_term_vec",  {56'b0, tv_w}, tv_m[0]);
        chk("wrap_sticky",    {56'b0, st_w}, st_m[0]);
        chk("wrap_cout",      {63'b0, co_w}, {63'b0, co_m[0]});
        chk("sat_term_vec",   {56'b0, tv_s}, tv_m[1]);
        chk("sat_sticky",     {56'b0, st_s}, st_m[1]);
        chk("sat_cout",       {63'b0, co_s}, {63'b0, co_m[1]});
        chk("scale_term_vec", tv_x, tv_m[2]);
        chk("scale_sticky",   st_x, st_m[2]);
        chk("scale_cout",     {63'b0, co_x}, {63'b0, co_m[2]});
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_n) model_step();
        #1;
        compare_all();
    endtask

    typedef struct {
        int   e;
        logic tvw, cow, stw, tvs, cos;
    } tvec_t;

    initial begin
        tvec_t       tbl [8];
        logic [4:0]  fall_tv;
        logic [4:0]  fall_co;
        bit          found;

        // Edge index, expected wrap term_vec[0]/cout/sticky[0], saturate term_vec[0]/cout.
        tbl[0] = '{16, 0, 0, 0, 0, 0};
        tbl[1] = '{17, 1, 0, 0, 1, 0};
        tbl[2] = '{18, 0, 1, 1, 1, 1};
        tbl[3] = '{19, 0, 0, 1, 1, 1};
        tbl[4] = '{32, 0, 0, 1, 1, 1};
        tbl[5] = '{33, 1, 0, 1, 1, 1};
        tbl[6] = '{34, 0, 1, 1, 1, 1};
        tbl[7] = '{35, 0, 0, 1, 1, 1};

        for (int k = 0; k < 3; k++) begin
            cen_a[k]  = '0;
            mask_a[k] = '0;
            clr_a[k]  = 1'b0;
        end
        model_reset();

        // Reset state.
        for (int n = 0; n < 3; n++) tick();
        chk("reset_wrap_outs",  {47'b0, tv_w, st_w, co_w}, 64'b0);
        chk("reset_scale_outs", tv_x | st_x | {63'b0, co_x}, 64'b0);

        // Synchronisation, wrap, saturate and scale timing; the first edge after this is E0.
        reset_n     = 1'b1;
        cen_a[0][0] = 1'b1;
        cen_a[1][0] = 1'b1;
        cen_a[2]    = '1;
        for (int e = 0; e < 40; e++) begin
            tick();
            for (int j = 0; j < 8; j++) begin
                if (tbl[j].e == e) begin
                    chk($sformatf("tbl_wrap_tv_E%0d", e),   {63'b0, tv_w[0]}, {63'b0, tbl[j].tvw});
                    chk($sformatf("tbl_wrap_cout_E%0d", e), {63'b0, co_w},    {63'b0, tbl[j].cow});
                    chk($sformatf("tbl_wrap_st_E%0d", e),   {63'b0, st_w[0]}, {63'b0, tbl[j].stw});
                    chk($sformatf("tbl_sat_tv_E%0d", e),    {63'b0, tv_s[0]}, {63'b0, tbl[j].tvs});
                    chk($sformatf("tbl_sat_cout_E%0d", e),  {63'b0, co_s},    {63'b0, tbl[j].cos});
                end
            end
            chk($sformatf("scale_tv_E%0d", e), tv_x, (e >= 4 && e % 4 == 0) ? '1 : '0);
            chk($sformatf("scale_cout_E%0d", e), {63'b0, co_x},
                {63'b0, (e >= 5 && e % 4 == 1)});
        end

        // Enable deassertion on the saturated channel; F0 is the first edge sampling cen=0.
        cen_a[0][0] = 1'b0;
        cen_a[1][0] = 1'b0;
        cen_a[2]    = '0;
        fall_tv = 5'b00111;
        fall_co = 5'b01111;
        for (int f = 0; f < 5; f++) begin
            tick();
            chk($sformatf("fall_sat_tv_F%0d", f),   {63'b0, tv_s[0]}, {63'b0, fall_tv[f]});
            chk($sformatf("fall_sat_cout_F%0d", f), {63'b0, co_s},    {63'b0, fall_co[f]});
        end

        // Mask: channels 3 and 5 saturated, only 3 masked, then both masked.
        cen_a[1][3] = 1'b1;
        cen_a[1][5] = 1'b1;
        mask_a[1]   = 64'h8;
        for (int n = 0; n < 20; n++) tick();
        chk("mask3_cout", {63'b0, co_s}, 64'd1);
        mask_a[1] = 64'h28;
        tick();
        chk("mask35_cout",   {63'b0, co_s}, 64'd0);
        chk("mask35_tv",     {62'b0, tv_s[5], tv_s[3]}, 64'd3);
        chk("mask35_sticky", {62'b0, st_s[5], st_s[3]}, 64'd3);
        cen_a[1]  = '0;
        mask_a[1] = '0;
        for (int n = 0; n < 6; n++) tick();

        // Sticky priority: clear while term_vec[2]=1, term_vec[4]=0 and both sticky set.
        cen_a[0][4] = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        cen_a[0][2] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            tick();
            found = tv_m[0][2] && !tv_m[0][4] && st_m[0][2] && st_m[0][4];
        end
        chk("sticky_setup_reached", {63'b0, found}, 64'd1);
        clr_a[0] = 1'b1;
        tick();
        clr_a[0] = 1'b0;
        chk("sticky_clr_keeps2", {63'b0, st_w[2]}, 64'd1);
        chk("sticky_clr_clears4", {63'b0, st_w[4]}, 64'd0);

        // Randomised traffic on all three instances against the model.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < p_n(k); i++) begin
                    if ($urandom_range(0, 19) == 0) cen_a[k][i] = ~cen_a[k][i];
                end
                if ($urandom_range(0, 7) == 0) mask_a[k] = {$urandom, $urandom};
                clr_a[k] = ($urandom_range(0, 9) == 0);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            clr_a[k]  = 1'b0;
            mask_a[k] = '0;
        end

        // Reset asserted mid-count between edges, then released with cen[0] held high.
        cen_a[0][0] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            tick();
            found = (cnt_m[0][0] == 9) && (st_m[0] != 0);
        end
        chk("midreset_setup_reached", {63'b0, found}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midreset_wrap_tv",     {56'b0, tv_w}, 64'd0);
        chk("midreset_wrap_sticky", {56'b0, st_w}, 64'd0);
        chk("midreset_wrap_cout",   {63'b0, co_w}, 64'd0);
        chk("midreset_sat_sticky",  {56'b0, st_s}, 64'd0);
        chk("midreset_scale_all",   tv_x | st_x, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int e = 0; e < 18; e++) begin
            tick();
            if (e == 16) chk("restart_tv_E16", {63'b0, tv_w[0]}, 64'd0);
            if (e == 17) chk("restart_tv_E17", {63'b0, tv_w[0]}, 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
